// File: rtl/tron_pkg.sv
// Shared types and helpers for the Tron turn controller.
//   heading_t    : 2-bit compass heading, 0=N 1=E 2=S 3=W
//   turn_t       : relative turn request stored in the per-player FIFOs
//   game_state_t : game run state owned by tron_turn_ctrl
//   turn_apply   : heading after applying one relative turn (mod-4 wrap)
package tron_pkg;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_E = 2'd1,
        HEAD_S = 2'd2,
        HEAD_W = 2'd3
    } heading_t;

    typedef enum logic {
        TURN_L = 1'b0,
        TURN_R = 1'b1
    } turn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } game_state_t;

    // Right turn is +1, left turn is -1; the 2-bit arithmetic gives the
    // 3->0 and 0->3 wrap for free.
    function automatic heading_t turn_apply(input heading_t h, input turn_t t);
        logic [1:0] n;
        if (t == TURN_R) n = h + 2'd1;
        else             n = h - 2'd1;
        return heading_t'(n);
    endfunction

endpackage

// File: rtl/tron_turn_fifo.sv
// Per-player turn-request FIFO.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   flush          : empties the FIFO (takes priority over push/pop)
//   push/push_data : enqueue request; ignored when full unless popping too
//   pop            : dequeue head; ignored when empty
//   pop_data       : current head entry (valid when !empty)
//   empty, full    : occupancy flags
module tron_turn_fifo
    import tron_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  flush,
    input  logic  push,
    input  turn_t push_data,
    input  logic  pop,
    output turn_t pop_data,
    output logic  empty,
    output logic  full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    turn_t         mem [FIFO_DEPTH];
    logic          do_pop;
    logic          do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop_data = mem[rd_ptr];

    // A pop on empty does nothing, so a same-cycle push is simply stored.
    // A push on full is accepted only when a pop frees the head slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tron_turn_ctrl.sv
// Tron light-cycle turn controller: turns debounced button presses into
// tick-aligned heading updates for two players and owns the IDLE/RUN/HALT
// game state.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   btn_left, btn_right   : debounced button levels, bit p = player p
//   tick                  : game-step strobe; pops one turn per player
//   crash                 : collision strobe, RUN -> HALT
//   new_game              : return to IDLE, reload headings, flush queues
//   running               : high while in RUN
//   heading0, heading1    : current player headings (0=N 1=E 2=S 3=W)
//   turned                : per-player pulse, heading changed this cycle
//   dropped               : per-player pulse, request lost to a full FIFO
// Optional build macro TRON_AUTOREPEAT_EN: a button held in RUN emits an
// extra request every REPEAT_TICKS ticks.
module tron_turn_ctrl
    import tron_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 2,
    parameter logic [1:0] INIT_HEADING0 = 2'd1,
    parameter logic [1:0] INIT_HEADING1 = 2'd3,
    parameter int         REPEAT_TICKS  = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] btn_left,
    input  logic [1:0] btn_right,
    input  logic       tick,
    input  logic       crash,
    input  logic       new_game,
    output logic       running,
    output logic [1:0] heading0,
    output logic [1:0] heading1,
    output logic [1:0] turned,
    output logic [1:0] dropped
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tron_turn_ctrl: FIFO_DEPTH must be a power of two in 2..8");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("tron_turn_ctrl: REPEAT_TICKS must be at least 1");
    end

    game_state_t state;
    heading_t    heading [2];
    logic [1:0]  prev_left;
    logic [1:0]  prev_right;
    logic [1:0]  rise_l;
    logic [1:0]  rise_r;
    logic [1:0]  rep_l;
    logic [1:0]  rep_r;
    logic [1:0]  req_l;
    logic [1:0]  req_r;
    logic        run_active;
    logic        flush;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [1:0]  do_pop;
    logic [1:0]  drop_now;
    logic [1:0]  empty;
    logic [1:0]  full;
    turn_t       push_data [2];
    turn_t       pop_data  [2];

    assign rise_l = btn_left  & ~prev_left;
    assign rise_r = btn_right & ~prev_right;

    // new_game overrides everything else in the cycle it arrives.
    assign run_active = (state == RUN) && !new_game;
    assign flush      = (state != RUN) || new_game;

`ifdef TRON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [RW-1:0] rep_cnt_l [2];
    logic [RW-1:0] rep_cnt_r [2];

    always_comb begin
        rep_l = '0;
        rep_r = '0;
        for (int p = 0; p < 2; p++) begin
            rep_l[p] = run_active && tick && btn_left[p]  && (rep_cnt_l[p] == RW'(REPEAT_TICKS - 1));
            rep_r[p] = run_active && tick && btn_right[p] && (rep_cnt_r[p] == RW'(REPEAT_TICKS - 1));
        end
    end

    // Tick counters per held button; restart after each repeat request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                rep_cnt_l[p] <= '0;
                rep_cnt_r[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!run_active || !btn_left[p]) rep_cnt_l[p] <= '0;
                else if (tick)                   rep_cnt_l[p] <= rep_l[p] ? '0 : rep_cnt_l[p] + 1'b1;
                if (!run_active || !btn_right[p]) rep_cnt_r[p] <= '0;
                else if (tick)                    rep_cnt_r[p] <= rep_r[p] ? '0 : rep_cnt_r[p] + 1'b1;
            end
        end
    end
`else
    assign rep_l = '0;
    assign rep_r = '0;
`endif

    assign req_l = rise_l | rep_l;
    assign req_r = rise_r | rep_r;

    // Simultaneous left and right requests cancel each other silently.
    assign push     = {2{run_active}} & (req_l ^ req_r);
    assign pop      = {2{run_active && tick}};
    assign do_pop   = pop & ~empty;
    assign drop_now = push & full & ~do_pop;

    for (genvar p = 0; p < 2; p++) begin : g_player
        assign push_data[p] = req_l[p] ? TURN_L : TURN_R;

        tron_turn_fifo #(
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .push     (push[p]),
            .push_data(push_data[p]),
            .pop      (pop[p]),
            .pop_data (pop_data[p]),
            .empty    (empty[p]),
            .full     (full[p])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            heading[0] <= heading_t'(INIT_HEADING0);
            heading[1] <= heading_t'(INIT_HEADING1);
            prev_left  <= '0;
            prev_right <= '0;
            turned     <= '0;
            dropped    <= '0;
        end else begin
            prev_left  <= btn_left;
            prev_right <= btn_right;
            turned     <= '0;
            dropped    <= '0;
            if (new_game) begin
                state      <= IDLE;
                heading[0] <= heading_t'(INIT_HEADING0);
                heading[1] <= heading_t'(INIT_HEADING1);
            end else begin
                case (state)
                    IDLE: begin
                        // The starting press only launches the game.
                        if ((rise_l | rise_r) != '0) state <= RUN;
                    end
                    RUN: begin
                        for (int p = 0; p < 2; p++) begin
                            if (do_pop[p]) begin
                                heading[p] <= turn_apply(heading[p], pop_data[p]);
                                turned[p]  <= 1'b1;
                            end
                        end
                        dropped <= drop_now;
                        if (crash) state <= HALT;
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign running  = (state == RUN);
    assign heading0 = heading[0];
    assign heading1 = heading[1];

endmodule
